// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter: IFU/LSU arbiter onto one shared memory port, one txn in flight |
// | Optional: define ARB_RR_EN for round-robin tie-break (else LSU priority)    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        slv_req_valid,
  input  logic        slv_req_ready,
  output logic [31:0] slv_addr,
  output logic        slv_wen,
  output logic [31:0] slv_wdata,
  output logic [3:0]  slv_wmask,
  input  logic        slv_resp_valid,
  input  logic [31:0] slv_rdata,
  output logic        arb_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        grant_lsu_q, grant_lsu_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  logic        pick_lsu;
  logic        ifu_grant;
  logic        lsu_grant;
  logic        resp_fire;
  logic        resp_timeout;
  logic [31:0] resp_data;

`ifdef ARB_RR_EN
  logic last_lsu_q, last_lsu_d;

  // On a tie, serve whichever master did not win the previous grant
  always_comb pick_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu_q);

  always_comb begin
    last_lsu_d = last_lsu_q;
    if (ifu_grant || lsu_grant) last_lsu_d = lsu_grant;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_lsu_q <= 1'b0;
    else      last_lsu_q <= last_lsu_d;
  end
`else
  always_comb pick_lsu = lsu_req_valid;
`endif

  always_comb begin
    state_d      = state_q;
    grant_lsu_d  = grant_lsu_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    ifu_grant    = 1'b0;
    lsu_grant    = 1'b0;
    resp_fire    = 1'b0;
    resp_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ifu_req_valid || lsu_req_valid) begin
          lsu_grant   = pick_lsu;
          ifu_grant   = !pick_lsu;
          grant_lsu_d = pick_lsu;
          // Instruction fetches are always plain reads with no byte lanes
          addr_d      = pick_lsu ? lsu_addr : ifu_addr;
          wen_d       = pick_lsu && lsu_wen;
          wdata_d     = pick_lsu ? lsu_wdata : 32'h0;
          wmask_d     = pick_lsu ? lsu_wmask : 4'h0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (slv_req_ready) begin
          state_d = ST_RESP;
          cnt_d   = 8'd0;
        end
      end
      ST_RESP: begin
        resp_timeout = !slv_resp_valid && (cnt_q == TIMEOUT_CNT);
        resp_fire    = slv_resp_valid || resp_timeout;
        if (resp_fire) begin
          state_d = ST_IDLE;
          if (resp_timeout) timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_lsu_q <= 1'b0;
      addr_q      <= 32'h0;
      wen_q       <= 1'b0;
      wdata_q     <= 32'h0;
      wmask_q     <= 4'h0;
      cnt_q       <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_lsu_q <= grant_lsu_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Grants are combinational on the inputs, so hold them low while in reset
  assign ifu_req_ready  = ifu_grant && rst;
  assign lsu_req_ready  = lsu_grant && rst;

  assign resp_data      = slv_resp_valid ? slv_rdata : 32'h0;
  assign ifu_resp_valid = resp_fire && !grant_lsu_q;
  assign lsu_resp_valid = resp_fire && grant_lsu_q;
  assign ifu_rdata      = ifu_resp_valid ? resp_data : 32'h0;
  assign lsu_rdata      = lsu_resp_valid ? resp_data : 32'h0;

  assign slv_req_valid  = (state_q == ST_REQ);
  assign slv_addr       = addr_q;
  assign slv_wen        = wen_q;
  assign slv_wdata      = wdata_q;
  assign slv_wmask      = wmask_q;
  assign arb_timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Bench for mem_arbiter: directed vector table, corner-case sequences, then
// random traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TO = 8;
`ifdef ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        slv_req_valid, slv_req_ready, slv_wen, slv_resp_valid;
  logic [31:0] slv_addr, slv_wdata, slv_rdata;
  logic [3:0]  slv_wmask;
  logic        arb_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .slv_req_valid(slv_req_valid), .slv_req_ready(slv_req_ready), .slv_addr(slv_addr),
    .slv_wen(slv_wen), .slv_wdata(slv_wdata), .slv_wmask(slv_wmask),
    .slv_resp_valid(slv_resp_valid), .slv_rdata(slv_rdata),
    .arb_timeout(arb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ifu_v; logic [31:0] ifu_a;
    logic lsu_v; logic [31:0] lsu_a; logic wen; logic [31:0] wd; logic [3:0] wm;
    logic s_rdy; logic s_resp; logic [31:0] s_rd;
    logic e_ifu_rdy; logic e_lsu_rdy;
    logic e_sreq; logic [31:0] e_saddr; logic e_swen; logic [31:0] e_swd; logic [3:0] e_swm;
    logic e_ifu_rv; logic e_lsu_rv; logic [31:0] e_rd;
  } vec_t;

  vec_t vec [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; ifu_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    slv_req_ready = 1'b0; slv_resp_valid = 1'b0; slv_rdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
  endtask

  // Slave accepts at once, then answers with d; checks the owner's response
  task automatic finish_txn(input logic exp_lsu, input logic [31:0] d);
    slv_req_ready = 1'b1;
    #1;
    check("fin slv_req_valid", 32'(slv_req_valid), 32'd1);
    check("fin ifu_ready_busy", 32'(ifu_req_ready), 32'd0);
    check("fin lsu_ready_busy", 32'(lsu_req_ready), 32'd0);
    tick();
    slv_req_ready = 1'b0; slv_resp_valid = 1'b1; slv_rdata = d;
    #1;
    check("fin ifu_resp_valid", 32'(ifu_resp_valid), 32'(!exp_lsu));
    check("fin lsu_resp_valid", 32'(lsu_resp_valid), 32'(exp_lsu));
    check("fin rdata", exp_lsu ? lsu_rdata : ifu_rdata, d);
    tick();
    slv_resp_valid = 1'b0;
  endtask

  // Reference model state (transaction level)
  logic        m_busy, m_acc, m_own_lsu, m_last_lsu, m_to;
  logic [31:0] m_addr, m_wd;
  logic        m_wen;
  logic [3:0]  m_wm;
  int          m_wait;

  initial begin
    logic exp_lsu2;
    rst = 1'b0;
    idle_inputs();
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #2;
    check("rst ifu_ready", 32'(ifu_req_ready), 32'd0);
    check("rst lsu_ready", 32'(lsu_req_ready), 32'd0);
    check("rst slv_req_valid", 32'(slv_req_valid), 32'd0);
    check("rst slv_addr", slv_addr, 32'h0);
    check("rst arb_timeout", 32'(arb_timeout), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    idle_inputs();

    // ifu_v ifu_a lsu_v lsu_a wen wd wm | s_rdy s_resp s_rd | e_ifu_rdy e_lsu_rdy e_sreq saddr swen swd swm e_ifu_rv e_lsu_rv e_rd
    vec[0]  = '{1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vec[1]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vec[2]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vec[3]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0297,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0000_0297};
    vec[4]  = vec[2];
    vec[5]  = '{1'b0, 32'h0, 1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vec[6]  = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0};
    vec[7]  = vec[6];
    vec[8]  = vec[6];
    vec[9]  = vec[6];
    vec[9].s_rdy = 1'b1;
    vec[10] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0};
    vec[11] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0055,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vec[12] = '{1'b0, 32'h0, 1'b1, 32'h8000_1004, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vec[13] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0000_0077,
                1'b0, 1'b0, 1'b1, 32'h8000_1004, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vec[14] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D};

    for (int i = 0; i < 15; i++) begin
      ifu_req_valid = vec[i].ifu_v; ifu_addr = vec[i].ifu_a;
      lsu_req_valid = vec[i].lsu_v; lsu_addr = vec[i].lsu_a; lsu_wen = vec[i].wen;
      lsu_wdata = vec[i].wd; lsu_wmask = vec[i].wm;
      slv_req_ready = vec[i].s_rdy; slv_resp_valid = vec[i].s_resp; slv_rdata = vec[i].s_rd;
      #1;
      check($sformatf("vec%0d ifu_ready", i), 32'(ifu_req_ready), 32'(vec[i].e_ifu_rdy));
      check($sformatf("vec%0d lsu_ready", i), 32'(lsu_req_ready), 32'(vec[i].e_lsu_rdy));
      check($sformatf("vec%0d slv_req_valid", i), 32'(slv_req_valid), 32'(vec[i].e_sreq));
      if (vec[i].e_sreq) begin
        check($sformatf("vec%0d slv_addr", i), slv_addr, vec[i].e_saddr);
        check($sformatf("vec%0d slv_wen", i), 32'(slv_wen), 32'(vec[i].e_swen));
        check($sformatf("vec%0d slv_wdata", i), slv_wdata, vec[i].e_swd);
        check($sformatf("vec%0d slv_wmask", i), 32'(slv_wmask), 32'(vec[i].e_swm));
      end
      check($sformatf("vec%0d ifu_resp_valid", i), 32'(ifu_resp_valid), 32'(vec[i].e_ifu_rv));
      check($sformatf("vec%0d lsu_resp_valid", i), 32'(lsu_resp_valid), 32'(vec[i].e_lsu_rv));
      check($sformatf("vec%0d ifu_rdata", i), ifu_rdata, vec[i].e_ifu_rv ? vec[i].e_rd : 32'h0);
      check($sformatf("vec%0d lsu_rdata", i), lsu_rdata, vec[i].e_lsu_rv ? vec[i].e_rd : 32'h0);
      tick();
    end
    idle_inputs();
    check("vec arb_timeout", 32'(arb_timeout), 32'd0);

    // Arbitration ties: first tie after reset goes to LSU; the next depends on mode
    reset_dut();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
    #1;
    check("tie1 lsu_ready", 32'(lsu_req_ready), 32'd1);
    check("tie1 ifu_ready", 32'(ifu_req_ready), 32'd0);
    tick();
    lsu_req_valid = 1'b0;
    finish_txn(1'b1, 32'h1111_1111);
    exp_lsu2 = !RR_MODE;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2004;
    #1;
    check("tie2 lsu_ready", 32'(lsu_req_ready), 32'(exp_lsu2));
    check("tie2 ifu_ready", 32'(ifu_req_ready), 32'(!exp_lsu2));
    tick();
    if (exp_lsu2) lsu_req_valid = 1'b0;
    else          ifu_req_valid = 1'b0;
    finish_txn(exp_lsu2, 32'h2222_2222);
    #1;
    check("tie3 lsu_ready", 32'(lsu_req_ready), 32'(!exp_lsu2));
    check("tie3 ifu_ready", 32'(ifu_req_ready), 32'(exp_lsu2));
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    finish_txn(!exp_lsu2, 32'h3333_3333);

    // Timeout: slave accepts but never answers
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    tick();
    ifu_req_valid = 1'b0; slv_req_ready = 1'b1;
    tick();
    slv_req_ready = 1'b0; slv_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < TO; k++) begin
      #1;
      check($sformatf("to wait%0d ifu_resp_valid", k), 32'(ifu_resp_valid), 32'd0);
      tick();
    end
    #1;
    check("to ifu_resp_valid", 32'(ifu_resp_valid), 32'd1);
    check("to ifu_rdata", ifu_rdata, 32'h0);
    check("to lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
    tick();
    check("to arb_timeout set", 32'(arb_timeout), 32'd1);
    ifu_req_valid = 1'b1;
    tick();
    ifu_req_valid = 1'b0;
    finish_txn(1'b0, 32'h4444_4444);
    check("to arb_timeout sticky", 32'(arb_timeout), 32'd1);

    // Reset while waiting for a response, then a late response must be dropped
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b1;
    lsu_wdata = 32'hA5A5_A5A5; lsu_wmask = 4'h3;
    tick();
    lsu_req_valid = 1'b0; slv_req_ready = 1'b1;
    tick();
    slv_req_ready = 1'b0; ifu_req_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("rstmid ifu_ready", 32'(ifu_req_ready), 32'd0);
    check("rstmid slv_req_valid", 32'(slv_req_valid), 32'd0);
    check("rstmid slv_addr", slv_addr, 32'h0);
    check("rstmid slv_wen", 32'(slv_wen), 32'd0);
    check("rstmid slv_wdata", slv_wdata, 32'h0);
    check("rstmid slv_wmask", 32'(slv_wmask), 32'd0);
    check("rstmid lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
    check("rstmid arb_timeout", 32'(arb_timeout), 32'd0);
    tick();
    ifu_req_valid = 1'b0;
    rst = 1'b1; slv_resp_valid = 1'b1; slv_rdata = 32'h0000_1234;
    #1;
    check("late ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
    check("late lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
    check("late lsu_rdata", lsu_rdata, 32'h0);
    tick();
    slv_resp_valid = 1'b0;
    #1;
    check("late2 lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
    check("late2 slv_req_valid", 32'(slv_req_valid), 32'd0);

    // Random traffic against the reference model
    reset_dut();
    m_busy = 1'b0; m_acc = 1'b0; m_own_lsu = 1'b0; m_last_lsu = 1'b0; m_to = 1'b0;
    m_addr = 32'h0; m_wd = 32'h0; m_wen = 1'b0; m_wm = 4'h0; m_wait = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic e_ifu_rdy, e_lsu_rdy, e_sreq, e_ifu_rv, e_lsu_rv, win_lsu, fin;
      logic [31:0] e_rd;
      if (!ifu_req_valid && $urandom_range(0, 9) < 4) begin
        ifu_req_valid = 1'b1; ifu_addr = $urandom;
      end
      if (!lsu_req_valid && $urandom_range(0, 9) < 4) begin
        lsu_req_valid = 1'b1; lsu_addr = $urandom; lsu_wen = 1'($urandom_range(0, 1));
        lsu_wdata = $urandom; lsu_wmask = 4'($urandom_range(0, 15));
      end
      slv_req_ready  = 1'($urandom_range(0, 1));
      slv_resp_valid = ($urandom_range(0, 9) < 3);
      slv_rdata      = $urandom;
      #1;
      e_ifu_rdy = 1'b0; e_lsu_rdy = 1'b0; e_sreq = 1'b0; e_ifu_rv = 1'b0; e_lsu_rv = 1'b0;
      e_rd = 32'h0; fin = 1'b0;
      win_lsu = (ifu_req_valid && lsu_req_valid) ? (RR_MODE ? !m_last_lsu : 1'b1) : lsu_req_valid;
      if (!m_busy) begin
        e_lsu_rdy = (ifu_req_valid || lsu_req_valid) && win_lsu;
        e_ifu_rdy = (ifu_req_valid || lsu_req_valid) && !win_lsu;
      end else if (!m_acc) begin
        e_sreq = 1'b1;
      end else if (slv_resp_valid || m_wait == TO) begin
        fin = 1'b1;
        e_rd = slv_resp_valid ? slv_rdata : 32'h0;
        e_lsu_rv = m_own_lsu;
        e_ifu_rv = !m_own_lsu;
      end
      check($sformatf("rnd%0d ifu_ready", cyc), 32'(ifu_req_ready), 32'(e_ifu_rdy));
      check($sformatf("rnd%0d lsu_ready", cyc), 32'(lsu_req_ready), 32'(e_lsu_rdy));
      check($sformatf("rnd%0d slv_req_valid", cyc), 32'(slv_req_valid), 32'(e_sreq));
      if (e_sreq) begin
        check($sformatf("rnd%0d slv_addr", cyc), slv_addr, m_addr);
        check($sformatf("rnd%0d slv_wen", cyc), 32'(slv_wen), 32'(m_wen));
        check($sformatf("rnd%0d slv_wdata", cyc), slv_wdata, m_wd);
        check($sformatf("rnd%0d slv_wmask", cyc), 32'(slv_wmask), 32'(m_wm));
      end
      check($sformatf("rnd%0d ifu_resp_valid", cyc), 32'(ifu_resp_valid), 32'(e_ifu_rv));
      check($sformatf("rnd%0d lsu_resp_valid", cyc), 32'(lsu_resp_valid), 32'(e_lsu_rv));
      check($sformatf("rnd%0d ifu_rdata", cyc), ifu_rdata, e_ifu_rv ? e_rd : 32'h0);
      check($sformatf("rnd%0d lsu_rdata", cyc), lsu_rdata, e_lsu_rv ? e_rd : 32'h0);
      check($sformatf("rnd%0d arb_timeout", cyc), 32'(arb_timeout), 32'(m_to));
      if (e_ifu_rdy || e_lsu_rdy) begin
        m_busy = 1'b1; m_acc = 1'b0; m_own_lsu = e_lsu_rdy; m_last_lsu = e_lsu_rdy;
        m_addr = e_lsu_rdy ? lsu_addr : ifu_addr;
        m_wen  = e_lsu_rdy && lsu_wen;
        m_wd   = e_lsu_rdy ? lsu_wdata : 32'h0;
        m_wm   = e_lsu_rdy ? lsu_wmask : 4'h0;
      end else if (e_sreq) begin
        if (slv_req_ready) begin m_acc = 1'b1; m_wait = 0; end
      end else if (fin) begin
        m_busy = 1'b0;
        if (!slv_resp_valid) m_to = 1'b1;
      end else if (m_busy) begin
        m_wait++;
      end
      tick();
      if (e_ifu_rdy) ifu_req_valid = 1'b0;
      if (e_lsu_rdy) lsu_req_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 expected finish earlier");
    $fatal(1);
  end

endmodule
`default_nettype wire
